// File: rtl/rv_fetch_unit_pkg.sv
// Shared fetch-path defines: PC/instruction widths, reset vector and the register bus shape.
// Imported by the fetch unit and its instruction buffer.
package rv_fetch_unit_pkg;

    localparam int          XLEN_DEFAULT     = 64;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
    localparam int          INST_W           = 32;

    localparam int REG_BUS_AW = 32;
    localparam int REG_BUS_DW = 32;

    typedef struct packed {
        logic                  vld;
        logic                  wr;
        logic [REG_BUS_AW-1:0] addr;
        logic [REG_BUS_DW-1:0] dat;
    } reg_bus_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO with occupancy count and synchronous flush.
// Latency: push visible at head on the next cycle.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module fetch_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rv_fetch_unit.sv
// In-order instruction fetch with credit-limited requests, redirect flush and response dropping.
// Latency: rvalid at T -> out_valid at T+1; with FETCH_BYPASS_EN an empty buffer forwards at T.
// Backpressure: out_ready low fills the buffer; requests stop once buffer + in-flight reach DEPTH.
module rv_fetch_unit
    import rv_fetch_unit_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEFAULT,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [XLEN-1:0]   out_pc
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 1;
    localparam int             EW      = INST_W + XLEN;
    localparam logic [CW:0]    CREDITS = DEPTH[CW:0];

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic [EW-1:0]   fifo_head;
    logic            gnt_fire;
    logic            rsp_keep;
    logic [XLEN-1:0] redirect_aligned;

    // Request PCs in issue order; responses (kept or dropped) retire entries in the same order.
    logic [XLEN-1:0] pcq_mem [DEPTH];
    logic [AW-1:0]   pcq_wr;
    logic [AW-1:0]   pcq_rd;
    logic [XLEN-1:0] rsp_pc;

    assign credit_used      = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req         = rst && !redirect_valid && !fifo_full && (credit_used < CREDITS);
    assign imem_addr        = fetch_pc;
    assign gnt_fire         = imem_req && imem_gnt;
    assign redirect_aligned = redirect_pc & ~XLEN'(3);
    assign rsp_pc           = pcq_mem[pcq_rd];
    assign rsp_keep         = rst && imem_rvalid && (drop_cnt == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    logic bypass_fire;

    assign bypass_fire = rsp_keep && fifo_empty;
    assign out_valid   = (!fifo_empty && !redirect_valid) || bypass_fire;
    assign out_inst    = bypass_fire ? imem_rdata : fifo_head[EW-1:XLEN];
    assign out_pc      = bypass_fire ? rsp_pc     : fifo_head[XLEN-1:0];
    assign fifo_push   = rsp_keep && !(bypass_fire && out_ready);
    assign fifo_pop    = !fifo_empty && !redirect_valid && out_ready;
`else
    assign out_valid   = !fifo_empty && !redirect_valid;
    assign out_inst    = fifo_head[EW-1:XLEN];
    assign out_pc      = fifo_head[XLEN-1:0];
    assign fifo_push   = rsp_keep;
    assign fifo_pop    = out_valid && out_ready;
`endif

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat ({imem_rdata, rsp_pc}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .flush    (redirect_valid),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (gnt_fire) begin
            pcq_mem[pcq_wr] <= fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
            end else if (gnt_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end

            case ({gnt_fire, imem_rvalid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            // Everything still in flight after this edge belongs to the old stream.
            if (redirect_valid) begin
                drop_cnt <= outstanding - CW'(imem_rvalid);
            end else if (imem_rvalid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end

            if (gnt_fire)    pcq_wr <= pcq_wr + AW'(1);
            if (imem_rvalid) pcq_rd <= pcq_rd + AW'(1);
        end
    end

endmodule
